// File: rtl/matrix_alu_pkg.sv
// Shared definitions for the sequential matrix ALU.
//   op_t    : operation codes carried on the 3-bit op port
//   state_t : controller states, also exported on the debug port
//   elem_idx / elem_lsb : row-major element addressing helpers
//   op_is_legal : true for the five supported op codes
package matrix_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_SCAL  = 3'd2,
      OP_MMUL  = 3'd3,
      OP_TRANS = 3'd4
   } op_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      RUN     = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Linear index of element (r,c) in an n-column row-major matrix.
   function automatic int elem_idx(input int r, input int c, input int n);
      return r * n + c;
   endfunction

   // Bit offset of element (r,c) for w-bit elements.
   function automatic int elem_lsb(input int r, input int c, input int n, input int w);
      return elem_idx(r, c, n) * w;
   endfunction

   function automatic logic op_is_legal(input logic [2:0] o);
      return (o <= 3'd4);
   endfunction

endpackage

// File: rtl/matrix_alu_seq_dot_lane.sv
// matrix_dot_lane: combinational N-lane signed dot product.
//   a_vec, b_vec : N packed W-bit signed elements, lane k at [k*W +: W]
//   sum          : full-width signed sum of the N products (2W+clog2(N) bits)
//   oor          : sum lies outside the W-bit signed range
// Driving a single lane and zeroing the rest yields a plain W x W product.
module matrix_dot_lane
   import matrix_alu_pkg::*;
#(
   parameter  int N  = 5,
   parameter  int W  = 8,
   localparam int AW = 2 * W + $clog2(N)
) (
   input  logic [N*W-1:0]       a_vec,
   input  logic [N*W-1:0]       b_vec,
   output logic signed [AW-1:0] sum,
   output logic                 oor
);

   logic signed [AW-1:0] prod [N];

   always_comb begin
      for (int k = 0; k < N; k++) begin
         prod[k] = AW'($signed(a_vec[k*W +: W])) * AW'($signed(b_vec[k*W +: W]));
      end
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < N; k++) begin
         sum = sum + prod[k];
      end
   end

   // In range exactly when every bit from the W-bit sign position upward agrees.
   assign oor = !((&sum[AW-1:W-1]) || (~|sum[AW-1:W-1]));

endmodule

// File: rtl/matrix_alu_seq.sv
// matrix_alu_seq: sequential N x N matrix ALU (add, sub, scalar multiply,
// matrix multiply, transpose) on W-bit signed row-major matrices.
//   clk, rst        : clock, synchronous active-high reset
//   start, op       : request and op code, sampled together
//   mat_a, mat_b    : operand matrices, scalar : scalar operand
//   busy, done      : in progress / one-cycle completion pulse
//   result          : result matrix, held between operations
//   overflow        : any element overflowed in the last operation
//   illegal         : last accepted op code was unsupported
//   state_dbg       : current controller state (state_t encoding)
//
// Handshake: start is accepted only while busy=0 (IDLE or DONE); on the
// accepting edge all operands are registered, so later input changes do not
// matter. busy stays high through CAPTURE and RUN, start is ignored (not
// queued) while busy, and done is high for exactly the one DONE cycle, never
// together with busy. Holding start in DONE chains the next op directly.
module matrix_alu_seq
   import matrix_alu_pkg::*;
#(
   parameter int N = 5,
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [N*N*W-1:0] mat_a,
   input  logic [N*N*W-1:0] mat_b,
   input  logic [W-1:0]     scalar,
   output logic             busy,
   output logic             done,
   output logic [N*N*W-1:0] result,
   output logic             overflow,
   output logic             illegal,
   output logic [1:0]       state_dbg
);

   localparam int MW = N * N * W;
   localparam int CW = $clog2(N);
   localparam int AW = 2 * W + $clog2(N);

   state_t        state_q, state_d;
   logic [MW-1:0] a_q, a_d, b_q, b_d;
   logic [MW-1:0] work_q, work_d, result_q, result_d;
   logic [W-1:0]  scalar_q, scalar_d;
   logic [2:0]    op_q, op_d;
   logic [CW-1:0] i_q, i_d, j_q, j_d;
   logic          ovf_acc_q, ovf_acc_d;
   logic          overflow_q, overflow_d;
   logic          illegal_q, illegal_d;

   logic [N*W-1:0]       lane_a   [N];
   logic [N*W-1:0]       lane_b   [N];
   logic signed [AW-1:0] lane_sum [N];
   logic                 lane_oor [N];

   // Lane 0 computes the MMUL dot product (row i of A with column j of B).
   // For SCAL each lane c produces one row element using only its lane 0,
   // which keeps SCAL at one row per cycle like the other element-wise ops.
   always_comb begin
      for (int c = 0; c < N; c++) begin
         lane_a[c] = '0;
         lane_b[c] = '0;
      end
      if (op_q == OP_MMUL) begin
         for (int k = 0; k < N; k++) begin
            lane_a[0][k*W +: W] = a_q[elem_lsb(int'(i_q), k, N, W) +: W];
            lane_b[0][k*W +: W] = b_q[elem_lsb(k, int'(j_q), N, W) +: W];
         end
      end else if (op_q == OP_SCAL) begin
         for (int c = 0; c < N; c++) begin
            lane_a[c][W-1:0] = a_q[elem_lsb(int'(i_q), c, N, W) +: W];
            lane_b[c][W-1:0] = scalar_q;
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_lane
      matrix_dot_lane #(.N(N), .W(W)) u_lane (
         .a_vec (lane_a[g]),
         .b_vec (lane_b[g]),
         .sum   (lane_sum[g]),
         .oor   (lane_oor[g])
      );
   end

   always_comb begin
      logic [W-1:0] ea, eb, er;
      logic         step_ovf, last;
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      scalar_d   = scalar_q;
      op_d       = op_q;
      i_d        = i_q;
      j_d        = j_q;
      work_d     = work_q;
      result_d   = result_q;
      ovf_acc_d  = ovf_acc_q;
      overflow_d = overflow_q;
      illegal_d  = illegal_q;
      ea         = '0;
      eb         = '0;
      er         = '0;
      step_ovf   = 1'b0;
      last       = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = CAPTURE;
               a_d       = mat_a;
               b_d       = mat_b;
               scalar_d  = scalar;
               op_d      = op;
               i_d       = '0;
               j_d       = '0;
               ovf_acc_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         CAPTURE: begin
            if (op_is_legal(op_q)) begin
               state_d = RUN;
            end else begin
               // Unsupported op: skip RUN, leave result untouched.
               state_d    = DONE;
               illegal_d  = 1'b1;
               overflow_d = 1'b0;
            end
         end
         RUN: begin
            if (op_q == OP_MMUL) begin
               work_d[elem_lsb(int'(i_q), int'(j_q), N, W) +: W] = lane_sum[0][W-1:0];
               step_ovf = lane_oor[0];
               last     = (i_q == CW'(N - 1)) && (j_q == CW'(N - 1));
               if (j_q == CW'(N - 1)) begin
                  j_d = '0;
                  i_d = i_q + 1'b1;
               end else begin
                  j_d = j_q + 1'b1;
               end
            end else begin
               for (int c = 0; c < N; c++) begin
                  ea = a_q[elem_lsb(int'(i_q), c, N, W) +: W];
                  eb = b_q[elem_lsb(int'(i_q), c, N, W) +: W];
                  case (op_q)
                     OP_ADD: begin
                        er = ea + eb;
                        step_ovf |= (ea[W-1] == eb[W-1]) && (er[W-1] != ea[W-1]);
                     end
                     OP_SUB: begin
                        er = ea - eb;
                        step_ovf |= (ea[W-1] != eb[W-1]) && (er[W-1] != ea[W-1]);
                     end
                     OP_SCAL: begin
                        er = lane_sum[c][W-1:0];
                        step_ovf |= lane_oor[c];
                     end
                     OP_TRANS: er = a_q[elem_lsb(c, int'(i_q), N, W) +: W];
                     default:  er = '0;
                  endcase
                  work_d[elem_lsb(int'(i_q), c, N, W) +: W] = er;
               end
               last = (i_q == CW'(N - 1));
               i_d  = i_q + 1'b1;
            end
            ovf_acc_d = ovf_acc_q | step_ovf;
            // Publish the whole buffer (including this step) in one edge.
            if (last) begin
               state_d    = DONE;
               result_d   = work_d;
               overflow_d = ovf_acc_d;
               illegal_d  = 1'b0;
               i_d        = '0;
               j_d        = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         scalar_q   <= '0;
         op_q       <= '0;
         i_q        <= '0;
         j_q        <= '0;
         work_q     <= '0;
         result_q   <= '0;
         ovf_acc_q  <= 1'b0;
         overflow_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         scalar_q   <= scalar_d;
         op_q       <= op_d;
         i_q        <= i_d;
         j_q        <= j_d;
         work_q     <= work_d;
         result_q   <= result_d;
         ovf_acc_q  <= ovf_acc_d;
         overflow_q <= overflow_d;
         illegal_q  <= illegal_d;
      end
   end

   assign busy      = (state_q == CAPTURE) || (state_q == RUN);
   assign done      = (state_q == DONE);
   assign result    = result_q;
   assign overflow  = overflow_q;
   assign illegal   = illegal_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Directed bench for matrix_alu_seq at N=5, W=8.
module tb_matrix_alu_seq;
   import matrix_alu_pkg::*;

   localparam int N  = 5;
   localparam int W  = 8;
   localparam int MW = N * N * W;

   logic          clk;
   logic          rst;
   logic          start;
   logic [2:0]    op;
   logic [MW-1:0] mat_a;
   logic [MW-1:0] mat_b;
   logic [W-1:0]  scalar;
   logic          busy;
   logic          done;
   logic [MW-1:0] result;
   logic          overflow;
   logic          illegal;
   logic [1:0]    state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [MW-1:0] exp_q[$];

   matrix_alu_seq #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .mat_a     (mat_a),
      .mat_b     (mat_b),
      .scalar    (scalar),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .overflow  (overflow),
      .illegal   (illegal),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- matrix helpers ----------------
   function automatic logic [MW-1:0] fill(input logic [W-1:0] v);
      logic [MW-1:0] m;
      for (int k = 0; k < N * N; k++) m[k*W +: W] = v;
      return m;
   endfunction

   function automatic logic [MW-1:0] ramp();
      logic [MW-1:0] m;
      for (int k = 0; k < N * N; k++) m[k*W +: W] = W'(k);
      return m;
   endfunction

   function automatic logic [MW-1:0] ident();
      logic [MW-1:0] m;
      m = '0;
      for (int r = 0; r < N; r++) m[(r*N+r)*W +: W] = 8'd1;
      return m;
   endfunction

   function automatic logic [MW-1:0] set_el(input logic [MW-1:0] m, input int r,
                                            input int c, input logic [W-1:0] v);
      logic [MW-1:0] t;
      t = m;
      t[(r*N+c)*W +: W] = v;
      return t;
   endfunction

   function automatic logic [MW-1:0] transpose(input logic [MW-1:0] m);
      logic [MW-1:0] t;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            t[(r*N+c)*W +: W] = m[(c*N+r)*W +: W];
      return t;
   endfunction

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // ---------------- driver ----------------
   // Entered and left at a falling edge. Issues one op, scrambles the inputs
   // after acceptance, optionally pulses start during busy (poke = cycle
   // index, 0 = none), waits for done with a bound and scores the outcome
   // against the head of exp_q.
   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input logic [W-1:0] s, input int poke, input int exp_cyc,
                         input logic exp_ovf, input logic exp_ill);
      logic [MW-1:0] exp_m;
      int cyc;
      start  = 1'b1;
      op     = o;
      mat_a  = a;
      mat_b  = b;
      scalar = s;
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      start  = 1'b0;
      op     = 3'd7;
      mat_a  = ~a;
      mat_b  = ~b;
      scalar = ~s;
      chk({tag, "_busy_after_accept"}, 256'(busy), 256'(1'b1));
      chk({tag, "_capture_state"}, 256'(state_dbg), 256'(CAPTURE));
      while (done !== 1'b1 && cyc < 100) begin
         if (cyc == poke) start = 1'b1;
         @(posedge clk);
         cyc++;
         @(negedge clk);
         start = 1'b0;
         chk({tag, "_busy_and_done"}, 256'(busy & done), 256'(1'b0));
      end
      chk({tag, "_latency"}, 256'(cyc), 256'(exp_cyc));
      chk({tag, "_done"}, 256'(done), 256'(1'b1));
      chk({tag, "_busy_in_done"}, 256'(busy), 256'(1'b0));
      exp_m = exp_q.pop_front();
      chk({tag, "_result"}, 256'(result), 256'(exp_m));
      chk({tag, "_overflow"}, 256'(overflow), 256'(exp_ovf));
      chk({tag, "_illegal"}, 256'(illegal), 256'(exp_ill));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [MW-1:0] prev;
      rst    = 1'b1;
      start  = 1'b0;
      op     = 3'd0;
      mat_a  = '0;
      mat_b  = '0;
      scalar = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 256'(busy), 256'(1'b0));
      chk("rst_done", 256'(done), 256'(1'b0));
      chk("rst_result", 256'(result), 256'(0));
      chk("rst_overflow", 256'(overflow), 256'(1'b0));
      chk("rst_illegal", 256'(illegal), 256'(1'b0));
      chk("rst_state", 256'(state_dbg), 256'(IDLE));
      rst = 1'b0;
      @(negedge clk);

      // ADD saturating to the top of the range without overflow.
      exp_q.push_back(fill(8'd127));
      run_op("add_127", OP_ADD, fill(8'd100), fill(8'd27), 8'd0, 0, 7, 1'b0, 1'b0);
      @(negedge clk);
      chk("idle_after_done", 256'(state_dbg), 256'(IDLE));
      chk("result_held", 256'(result), 256'(fill(8'd127)));

      // One element crosses +127: wraps to -128 and flags overflow.
      exp_q.push_back(set_el(fill(8'd127), 4, 4, 8'h80));
      run_op("add_ovf", OP_ADD, fill(8'd100), set_el(fill(8'd27), 4, 4, 8'd28),
             8'd0, 0, 7, 1'b1, 1'b0);
      repeat (2) @(negedge clk);

      // -128 - 1 wraps to 127; 0 - 1 = -1 elsewhere.
      exp_q.push_back(set_el(fill(8'hFF), 0, 0, 8'h7F));
      run_op("sub_ovf", OP_SUB, set_el(fill(8'd0), 0, 0, 8'h80), fill(8'd1),
             8'd0, 0, 7, 1'b1, 1'b0);

      // -1 * -128 = +128 does not fit; low byte 0x80. Back-to-back from DONE.
      exp_q.push_back(fill(8'h80));
      run_op("scal_neg1", OP_SCAL, fill(8'h80), fill(8'd0), 8'hFF, 0, 7, 1'b1, 1'b0);

      // 3 * 40 = 120, in range.
      exp_q.push_back(fill(8'd120));
      run_op("scal_3", OP_SCAL, fill(8'd40), fill(8'd0), 8'd3, 0, 7, 1'b0, 1'b0);
      @(negedge clk);

      // Identity x ramp reproduces the ramp; 25 steps + 2.
      exp_q.push_back(ramp());
      run_op("mmul_id", OP_MMUL, ident(), ramp(), 8'd0, 0, 27, 1'b0, 1'b0);
      @(negedge clk);

      exp_q.push_back(transpose(ramp()));
      run_op("trans", OP_TRANS, ramp(), fill(8'd0), 8'd0, 0, 7, 1'b0, 1'b0);
      chk("trans_el_0_1", 256'(result[(0*N+1)*W +: W]), 256'(8'd5));
      chk("trans_el_3_2", 256'(result[(3*N+2)*W +: W]), 256'(8'd13));
      @(negedge clk);

      // Every element 5 * 10 * 10 = 500 = 0x1F4.
      exp_q.push_back(fill(8'hF4));
      run_op("mmul_500", OP_MMUL, fill(8'd10), fill(8'd10), 8'd0, 0, 27, 1'b1, 1'b0);
      prev = fill(8'hF4);
      @(negedge clk);

      // Unsupported op: result untouched, overflow cleared, illegal set.
      exp_q.push_back(prev);
      run_op("illegal", 3'b111, ramp(), ramp(), 8'd9, 0, 2, 1'b0, 1'b1);
      @(negedge clk);

      // Reset in the middle of an MMUL (during RUN step 10).
      start = 1'b1;
      op    = OP_MMUL;
      mat_a = fill(8'd10);
      mat_b = fill(8'd10);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_run_busy", 256'(busy), 256'(1'b1));
      chk("mid_run_state", 256'(state_dbg), 256'(RUN));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_busy", 256'(busy), 256'(1'b0));
      chk("midrst_done", 256'(done), 256'(1'b0));
      chk("midrst_result", 256'(result), 256'(0));
      chk("midrst_overflow", 256'(overflow), 256'(1'b0));
      chk("midrst_illegal", 256'(illegal), 256'(1'b0));
      chk("midrst_state", 256'(state_dbg), 256'(IDLE));
      rst = 1'b0;

      // Fresh ADD after reset.
      exp_q.push_back(ramp());
      run_op("add_after_rst", OP_ADD, fill(8'd0), ramp(), 8'd0, 0, 7, 1'b0, 1'b0);
      @(negedge clk);

      // A start pulse while busy must not disturb the running ADD.
      exp_q.push_back(fill(8'd3) + ramp());
      run_op("add_poke", OP_ADD, fill(8'd3), ramp(), 8'd0, $urandom_range(1, 5),
             7, 1'b0, 1'b0);

      // Issued in the DONE cycle: accepted straight into CAPTURE.
      exp_q.push_back(fill(8'hF6));
      run_op("add_b2b", OP_ADD, fill(8'hFB), fill(8'hFB), 8'd0, 0, 7, 1'b0, 1'b0);
      @(negedge clk);
      chk("final_idle", 256'(state_dbg), 256'(IDLE));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_alu_seq.md
# matrix_alu_seq

Parametrised, sequential successor to the fixed 5x5 matrix ALU in the HPS–FPGA coprocessor datapath. It operates on N×N matrices of W-bit signed elements and supports element-wise add and subtract, scalar multiply, matrix multiply and transpose. Work runs over a single-issue start/busy/done handshake: one row per cycle for element-wise ops, one output element per cycle for matrix multiply. It replaces the always-parallel multiplier, which only latched results when the multiply finished, with a shared N-lane dot-product datapath and a common completion path for every op.

## Interface
- N, default 5, matrix dimension (rows = cols), N ≥ 2
- W, default 8, element width in bits, signed two's complement, W ≥ 4
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE or DONE
- op  in  3  operation code, sampled with start
- mat_a  in  N*N*W  operand A, row-major; element (r,c) at bits [(r*N+c)*W +: W]
- mat_b  in  N*N*W  operand B, same packing
- scalar  in  W  signed scalar for op SCAL
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- result  out  N*N*W  result matrix, same packing; held between operations
- overflow  out  1  sticky OR of per-element overflow for the last operation
- illegal  out  1  last accepted op code was unsupported

## Operation
- Op codes:
  - 000 ADD: A+B
  - 001 SUB: A−B
  - 010 SCAL: scalar·A
  - 011 MMUL: A×B
  - 100 TRANS: Aᵀ
  - 101–111 illegal
- Accepting start:
  - On accept, mat_a, mat_b, scalar and op are captured into internal registers.
  - Later input changes have no effect until the next accept.
- FSM states:
  - IDLE: start → CAPTURE
  - CAPTURE: legal op → RUN; illegal op → DONE with illegal=1
  - RUN: after the last step → DONE
  - DONE: start → CAPTURE; otherwise → IDLE
- RUN steps:
  - ADD, SUB, SCAL, TRANS: L = N steps, one row per step, row counter 0..N−1.
  - MMUL: L = N*N steps, one output element (i,j) per step. j increments fastest and wraps to 0 at N−1, incrementing i.
- Arithmetic, per element:
  - ADD/SUB: W-bit wrap result. Overflow when the operand signs match (ADD) or differ (SUB) and the result sign differs from A.
  - SCAL: full 2W-bit product; result is the low W bits. Overflow when the product lies outside [−2^(W−1), 2^(W−1)−1].
  - MMUL: dot product of N 2W-bit products in a 2W+clog2(N)-bit accumulator; result is the low W bits. Overflow when the final sum lies outside the W-bit signed range. Intermediate partial sums are not checked.
  - TRANS: never overflows.
- Results are written into a work buffer. At the final RUN step the work buffer copies to result and the sticky overflow copies to overflow, so result never shows partial data.
- Illegal op: result is unchanged, overflow=0, illegal=1.
- Outputs in each state:
  - busy=1 in CAPTURE and RUN.
  - done=1 only in DONE.
  - illegal and overflow update only on the edge entering DONE, then hold.
- start while busy=1 is ignored and not queued.
- Reset at any point, including mid-RUN:
  - state=IDLE; busy=0, done=0, overflow=0, illegal=0; result=0.
  - Counters and work buffer are cleared.

## Timing
- start=1 sampled at edge 0 → CAPTURE after edge 0.
- RUN steps complete at edges 2..L+1.
- DONE (done=1, busy=0) during the cycle after edge L+1.
- Legal op latency, start edge to done visible: L+2 cycles.
  - N=5 element-wise ops: 7 cycles.
  - N=5 MMUL: 27 cycles.
- Illegal op: done visible 2 cycles after the start edge.
- Back-to-back: start held high in DONE is accepted, so the next op's CAPTURE follows immediately. Sustained throughput is one op per L+2 cycles.

## Structure
- Shared package matrix_alu_pkg holds:
  - op_t enum (OP_ADD, OP_SUB, OP_SCAL, OP_MMUL, OP_TRANS)
  - state_t enum (IDLE, CAPTURE, RUN, DONE)
  - element-index helper functions for row-major packing
- One sub-module, matrix_dot_lane:
  - N parallel signed W×W multipliers feeding an adder tree.
  - Outputs the full-width sum and an out-of-range flag.
  - Combinational; reused for SCAL by driving one lane and zeroing the others.
- Top level holds the FSM, counters, capture registers, work buffer and output registers.

## Test plan
All scenarios use N=5, W=8.
- ADD: all A=100, B=27 → all result=127, overflow=0, done 7 cycles after start. Then A=100, B=28 at element (4,4) → that element = −128, overflow=1.
- SUB and SCAL:
  - A=−128 at (0,0), B=1 → result(0,0)=127, overflow=1.
  - SCAL with scalar=−1 on A=−128 → 0x80, overflow=1.
  - SCAL with scalar=3 on A=40 → 120, overflow=0.
- MMUL: A=identity, B=ramp 0..24 → result=B, overflow=0, done exactly 27 cycles after start. With A=B=all 10, every element = 500 → low byte 0xF4, overflow=1.
- TRANS: A=ramp 0..24 → result(r,c)=A(c,r). Then op=111 → done after 2 cycles, illegal=1, result unchanged.
- Handshake:
  - start pulses during RUN are ignored.
  - start held through DONE starts a second ADD with no IDLE cycle.
  - busy and done are never high together.
- Reset: assert rst at RUN step 10 of MMUL → next cycle busy=0, done=0, result=0. A fresh ADD then completes correctly.
